// File: rtl/frame_pkg.sv
// frame_pkg: shared constants, state encoding and checksum helper for the
// MHP frame datapath (receive parser and transmit side).
package frame_pkg;

  localparam int FRAME_LEN = 51;
  localparam int DST_OFS   = 0;
  localparam int SRC_OFS   = 2;
  localparam int SIZE_OFS  = 4;
  localparam int DT_OFS    = 6;
  localparam int PAY_OFS   = 7;
  localparam int SCS_OFS   = 49;
  localparam int PAYLOAD_W = 336;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One SCS term: byte zero-extended to 16 bits, then shifted by (n mod 4).
  function automatic logic [15:0] scs_term(input logic [7:0] b, input logic [1:0] sh);
    return {8'h00, b} << sh;
  endfunction

endpackage

// File: rtl/frame_scs_acc.sv
// frame_scs_acc: 16-bit wrap-around SCS accumulator. i_clr restarts the sum;
// when i_clr and i_en are both high the byte is the first term of a new frame.
// The 2-bit shift counter tracks (byte index mod 4).
module frame_scs_acc
  import frame_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [7:0]  i_data,
  output logic [15:0] o_sum
);

  logic [1:0]  r_sh;
  logic [15:0] r_sum;
  logic [1:0]  w_sh;
  logic [15:0] w_base;

  // Select the shift amount and base sum, restarting both on clear.
  always_comb begin
    w_sh   = r_sh;
    w_base = r_sum;
    if (i_clr) begin
      w_sh   = 2'd0;
      w_base = 16'd0;
    end else begin
      w_sh   = r_sh;
      w_base = r_sum;
    end
  end

  // Accumulate one shifted byte per enabled cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum <= 16'd0;
      r_sh  <= 2'd0;
    end else if (i_en) begin
      r_sum <= w_base + scs_term(i_data, w_sh);
      r_sh  <= w_sh + 2'd1;
    end else if (i_clr) begin
      r_sum <= 16'd0;
      r_sh  <= 2'd0;
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/frame_parser.sv
// frame_parser: rebuilds MHP header fields and payload from the received byte
// stream, checks the SCS and aborts frames on an inter-byte gap timeout.
// Optional build macro FRAME_PARSER_SCS_CHECK_EN enables the SCS accumulator
// and comparison; without it o_scs_err is tied low and the SCS bytes are
// consumed and ignored.
module frame_parser
  import frame_pkg::*;
#(
  parameter int GAP_TIMEOUT = 16
)
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           i_rdata,
  input  logic                 i_rvalid,
  output logic [15:0]          o_dst,
  output logic [15:0]          o_src,
  output logic [15:0]          o_size,
  output logic                 o_dir,
  output logic [6:0]           o_type,
  output logic [PAYLOAD_W-1:0] o_payload,
  output logic                 o_valid,
  output logic                 o_scs_err,
  output logic                 o_abort,
  output logic                 o_busy
);

  localparam int         SHIFT_W  = SCS_OFS * 8;
  localparam int         GAP_W    = $clog2(GAP_TIMEOUT + 1);
  localparam logic [5:0] LAST_IDX = 6'(FRAME_LEN - 1);
  localparam logic [5:0] SCS_IDX  = 6'(SCS_OFS);

  state_t                 r_state;
  logic [5:0]             r_cnt;
  logic [GAP_W-1:0]       r_gap;
  logic [SHIFT_W-1:0]     r_shift;
  logic [15:0]            r_dst;
  logic [15:0]            r_src;
  logic [15:0]            r_size;
  logic                   r_dir;
  logic [6:0]             r_type;
  logic [PAYLOAD_W-1:0]   r_payload;
  logic                   r_valid;
  logic                   r_scs_err;
  logic                   r_abort;
  logic                   w_start;
  logic                   w_shift_en;
  logic                   w_scs_err;

  // Frame start (byte 0 seen outside RECV) and header/payload byte capture.
  always_comb begin
    w_start    = 1'b0;
    w_shift_en = 1'b0;
    if (i_rvalid && (r_state != ST_RECV)) begin
      w_start    = 1'b1;
      w_shift_en = 1'b1;
    end else if (i_rvalid && (r_state == ST_RECV) && (r_cnt < SCS_IDX)) begin
      w_start    = 1'b0;
      w_shift_en = 1'b1;
    end else begin
      w_start    = 1'b0;
      w_shift_en = 1'b0;
    end
  end

`ifdef FRAME_PARSER_SCS_CHECK_EN
  logic [15:0] w_sum;
  logic [7:0]  r_scs_hi;

  frame_scs_acc u_scs_acc (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_start),
    .i_en   (w_shift_en),
    .i_data (i_rdata),
    .o_sum  (w_sum)
  );

  // Hold the received SCS high byte until the low byte arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scs_hi <= 8'h00;
    end else if (i_rvalid && (r_state == ST_RECV) && (r_cnt == SCS_IDX)) begin
      r_scs_hi <= i_rdata;
    end
  end

  assign w_scs_err = (w_sum != {r_scs_hi, i_rdata});
`else
  assign w_scs_err = 1'b0;
`endif

  // Receive FSM: byte/gap counting, field shift register and output commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 6'd0;
      r_gap     <= '0;
      r_shift   <= '0;
      r_dst     <= 16'd0;
      r_src     <= 16'd0;
      r_size    <= 16'd0;
      r_dir     <= 1'b0;
      r_type    <= 7'd0;
      r_payload <= '0;
      r_valid   <= 1'b0;
      r_scs_err <= 1'b0;
      r_abort   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_abort <= 1'b0;
      if (w_shift_en) begin
        r_shift <= {i_rdata, r_shift[SHIFT_W-1:8]};
      end
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_rvalid) begin
            r_cnt   <= 6'd1;
            r_gap   <= '0;
            r_state <= ST_RECV;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RECV: begin
          if (i_rvalid) begin
            r_gap <= '0;
            if (r_cnt == LAST_IDX) begin
              r_dst     <= r_shift[DST_OFS*8 +: 16];
              r_src     <= r_shift[SRC_OFS*8 +: 16];
              r_size    <= r_shift[SIZE_OFS*8 +: 16];
              r_dir     <= r_shift[DT_OFS*8 + 7];
              r_type    <= r_shift[DT_OFS*8 +: 7];
              r_payload <= r_shift[PAY_OFS*8 +: PAYLOAD_W];
              r_valid   <= 1'b1;
              r_scs_err <= w_scs_err;
              r_cnt     <= 6'd0;
              r_state   <= ST_DONE;
            end else begin
              r_cnt <= r_cnt + 6'd1;
            end
          end else if (r_gap == GAP_W'(GAP_TIMEOUT - 1)) begin
            r_abort <= 1'b1;
            r_gap   <= '0;
            r_cnt   <= 6'd0;
            r_state <= ST_IDLE;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_dst     = r_dst;
  assign o_src     = r_src;
  assign o_size    = r_size;
  assign o_dir     = r_dir;
  assign o_type    = r_type;
  assign o_payload = r_payload;
  assign o_valid   = r_valid;
  assign o_scs_err = r_scs_err;
  assign o_abort   = r_abort;
  assign o_busy    = (r_state == ST_RECV);

endmodule

// File: tb/tb_frame_parser.sv
// tb_frame_parser: directed self-checking bench for frame_parser.
module tb_frame_parser;

  logic         clk;
  logic         rst;
  logic [7:0]   i_rdata;
  logic         i_rvalid;
  logic [15:0]  o_dst;
  logic [15:0]  o_src;
  logic [15:0]  o_size;
  logic         o_dir;
  logic [6:0]   o_type;
  logic [335:0] o_payload;
  logic         o_valid;
  logic         o_scs_err;
  logic         o_abort;
  logic         o_busy;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  logic [7:0]   frame [0:50];
  logic [335:0] exp_pay;
  logic         seen_early;
  logic         seen_abort;
  logic         exp_scs_bad;

  frame_parser dut (
    .clk       (clk),
    .rst       (rst),
    .i_rdata   (i_rdata),
    .i_rvalid  (i_rvalid),
    .o_dst     (o_dst),
    .o_src     (o_src),
    .o_size    (o_size),
    .o_dir     (o_dir),
    .o_type    (o_type),
    .o_payload (o_payload),
    .o_valid   (o_valid),
    .o_scs_err (o_scs_err),
    .o_abort   (o_abort),
    .o_busy    (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle with the given inputs; outputs are observed 1 ns after the edge.
  task automatic cyc(input logic v, input logic [7:0] d);
    i_rvalid = v;
    i_rdata  = d;
    @(posedge clk);
    #1;
    cycle++;
  endtask

  // Fill the frame buffer: payload byte k = k, SCS bytes from the given value.
  task automatic build_frame(input logic [15:0] dst, input logic [15:0] src,
                             input logic [15:0] size, input logic dir,
                             input logic [6:0] typ, input logic [15:0] scs);
    frame[0] = dst[7:0];
    frame[1] = dst[15:8];
    frame[2] = src[7:0];
    frame[3] = src[15:8];
    frame[4] = size[7:0];
    frame[5] = size[15:8];
    frame[6] = {dir, typ};
    for (int k = 0; k < 42; k++) begin
      frame[7+k]       = 8'(k);
      exp_pay[k*8 +: 8] = 8'(k);
    end
    frame[49] = scs[15:8];
    frame[50] = scs[7:0];
  endtask

  // Send bytes 0..last_n with no idle except gap_len idles after byte gap_after.
  task automatic send_frame(input int gap_after, input int gap_len, input int last_n);
    seen_early = 1'b0;
    seen_abort = 1'b0;
    for (int n = 0; n <= last_n; n++) begin
      cyc(1'b1, frame[n]);
      if (o_abort) seen_abort = 1'b1;
      if ((n < 50) && o_valid) seen_early = 1'b1;
      if (n == gap_after) begin
        for (int g = 0; g < gap_len; g++) begin
          cyc(1'b0, 8'h00);
          if (o_abort) seen_abort = 1'b1;
          if (o_valid) seen_early = 1'b1;
        end
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cyc(1'b0, 8'h00);
    cyc(1'b0, 8'h00);
    checks++;
    if ({o_dst, o_src, o_size, o_dir, o_type} !== 56'h0) begin
      errors++;
      $display("FAIL reset_fields: got %h expected 0", {o_dst, o_src, o_size, o_dir, o_type});
    end
    checks++;
    if ({o_payload, o_valid, o_scs_err, o_abort, o_busy} !== 340'h0) begin
      errors++;
      $display("FAIL reset_flags: got v=%b e=%b a=%b b=%b expected all 0", o_valid, o_scs_err, o_abort, o_busy);
    end
    rst = 1'b0;
    cyc(1'b0, 8'h00);
  endtask

  task automatic test_good_frame;
    build_frame(16'h1234, 16'hABCD, 16'h002A, 1'b1, 7'h05, 16'h17C1);
    send_frame(-1, 0, 50);
    checks++;
    if (seen_early !== 1'b0 || o_valid !== 1'b1) begin
      errors++;
      $display("FAIL good_latency: got early=%b valid=%b expected early=0 valid=1", seen_early, o_valid);
    end
    checks++;
    if ({o_dst, o_src, o_size} !== 48'h1234_ABCD_002A) begin
      errors++;
      $display("FAIL good_addr: got %h expected 1234abcd002a", {o_dst, o_src, o_size});
    end
    checks++;
    if (o_dir !== 1'b1 || o_type !== 7'h05) begin
      errors++;
      $display("FAIL good_dirtype: got dir=%b type=%h expected dir=1 type=05", o_dir, o_type);
    end
    checks++;
    if (o_payload !== exp_pay) begin
      errors++;
      $display("FAIL good_payload: got %h expected %h", o_payload, exp_pay);
    end
    checks++;
    if (o_scs_err !== 1'b0) begin
      errors++;
      $display("FAIL good_scs: got %b expected 0", o_scs_err);
    end
    cyc(1'b0, 8'h00);
    checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_dst !== 16'h1234) begin
      errors++;
      $display("FAIL good_pulse: got valid=%b busy=%b dst=%h expected 0 0 1234", o_valid, o_busy, o_dst);
    end
  endtask

  task automatic test_scs_error;
    build_frame(16'h1234, 16'hABCD, 16'h002A, 1'b1, 7'h05, 16'h17C1);
    frame[10] = frame[10] ^ 8'h01;
    exp_pay[3*8 +: 8] = 8'h02;
`ifdef FRAME_PARSER_SCS_CHECK_EN
    exp_scs_bad = 1'b1;
`else
    exp_scs_bad = 1'b0;
`endif
    send_frame(-1, 0, 50);
    checks++;
    if (o_valid !== 1'b1 || o_scs_err !== exp_scs_bad) begin
      errors++;
      $display("FAIL scs_err: got valid=%b err=%b expected valid=1 err=%b", o_valid, o_scs_err, exp_scs_bad);
    end
    checks++;
    if (o_payload !== exp_pay) begin
      errors++;
      $display("FAIL scs_payload: got %h expected %h", o_payload, exp_pay);
    end
    cyc(1'b0, 8'h00);
  endtask

  task automatic test_gap_abort;
    build_frame(16'h1234, 16'hABCD, 16'h002A, 1'b1, 7'h05, 16'h17C1);
    send_frame(-1, 0, 20);
    for (int g = 0; g < 15; g++) begin
      cyc(1'b0, 8'h00);
      if (o_abort) seen_abort = 1'b1;
    end
    checks++;
    if (seen_abort !== 1'b0 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL gap_pre_abort: got abort_seen=%b busy=%b expected 0 1", seen_abort, o_busy);
    end
    cyc(1'b0, 8'h00);
    checks++;
    if (o_abort !== 1'b1 || o_busy !== 1'b0 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL gap_abort: got abort=%b busy=%b valid=%b expected 1 0 0", o_abort, o_busy, o_valid);
    end
    checks++;
    if (o_payload[31:24] !== 8'h02 || o_dst !== 16'h1234) begin
      errors++;
      $display("FAIL gap_hold: got pay3=%h dst=%h expected 02 1234", o_payload[31:24], o_dst);
    end
    cyc(1'b0, 8'h00);
    checks++;
    if (o_abort !== 1'b0) begin
      errors++;
      $display("FAIL gap_abort_pulse: got %b expected 0", o_abort);
    end
    send_frame(-1, 0, 50);
    checks++;
    if (o_valid !== 1'b1 || o_scs_err !== 1'b0 || o_payload !== exp_pay || seen_abort !== 1'b0) begin
      errors++;
      $display("FAIL gap_recover: got valid=%b err=%b abort_seen=%b expected 1 0 0", o_valid, o_scs_err, seen_abort);
    end
    cyc(1'b0, 8'h00);
  endtask

  task automatic test_back_to_back;
    int c1;
    logic v1;
    logic e1;
    logic [15:0] d1;
    build_frame(16'h1234, 16'hABCD, 16'h002A, 1'b1, 7'h05, 16'h17C1);
    send_frame(-1, 0, 50);
    c1 = cycle;
    v1 = o_valid;
    e1 = o_scs_err;
    d1 = o_dst;
    frame[0]  = 8'h35;
    frame[49] = 8'h17;
    frame[50] = 8'hC2;
    send_frame(-1, 0, 50);
    checks++;
    if (v1 !== 1'b1 || e1 !== 1'b0 || d1 !== 16'h1234) begin
      errors++;
      $display("FAIL b2b_first: got valid=%b err=%b dst=%h expected 1 0 1234", v1, e1, d1);
    end
    checks++;
    if (o_valid !== 1'b1 || seen_early !== 1'b0 || (cycle - c1) !== 51) begin
      errors++;
      $display("FAIL b2b_second: got valid=%b early=%b spacing=%0d expected 1 0 51", o_valid, seen_early, cycle - c1);
    end
    checks++;
    if (o_dst !== 16'h1235 || o_scs_err !== 1'b0 || o_payload !== exp_pay) begin
      errors++;
      $display("FAIL b2b_fields: got dst=%h err=%b expected 1235 0", o_dst, o_scs_err);
    end
    cyc(1'b0, 8'h00);
  endtask

  task automatic test_reset_mid;
    build_frame(16'h1234, 16'hABCD, 16'h002A, 1'b1, 7'h05, 16'h17C1);
    send_frame(-1, 0, 29);
    rst = 1'b1;
    cyc(1'b1, frame[30]);
    rst = 1'b0;
    checks++;
    if ({o_dst, o_src, o_size, o_dir, o_type} !== 56'h0 || o_payload !== 336'h0) begin
      errors++;
      $display("FAIL rst_mid_fields: got %h expected 0", {o_dst, o_src, o_size, o_dir, o_type});
    end
    checks++;
    if ({o_valid, o_scs_err, o_abort, o_busy} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_mid_flags: got %b expected 0000", {o_valid, o_scs_err, o_abort, o_busy});
    end
    send_frame(-1, 0, 50);
    checks++;
    if (o_valid !== 1'b1 || {o_dst, o_src, o_size} !== 48'h1234_ABCD_002A || o_payload !== exp_pay || o_scs_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_recover: got valid=%b fields=%h err=%b expected 1 1234abcd002a 0", o_valid, {o_dst, o_src, o_size}, o_scs_err);
    end
    cyc(1'b0, 8'h00);
  endtask

  task automatic test_gap_15;
    build_frame(16'h1234, 16'hABCD, 16'h002A, 1'b1, 7'h05, 16'h17C1);
    send_frame(40, 15, 50);
    checks++;
    if (seen_abort !== 1'b0 || seen_early !== 1'b0 || o_valid !== 1'b1) begin
      errors++;
      $display("FAIL gap15: got abort_seen=%b early=%b valid=%b expected 0 0 1", seen_abort, seen_early, o_valid);
    end
    checks++;
    if (o_payload !== exp_pay || o_scs_err !== 1'b0 || o_type !== 7'h05) begin
      errors++;
      $display("FAIL gap15_fields: got type=%h err=%b expected 05 0", o_type, o_scs_err);
    end
    cyc(1'b0, 8'h00);
  endtask

  initial begin
    rst      = 1'b1;
    i_rvalid = 1'b0;
    i_rdata  = 8'h00;
    test_reset();
    test_good_frame();
    test_scs_error();
    test_gap_abort();
    test_back_to_back();
    test_reset_mid();
    test_gap_15();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
